// File: rtl/fifo_tx_scheduler.sv
// Purpose : drains a first-word-fall-through FIFO into a UART transmitter one word at a time.
// Latency : Rinc rises one edge after the start condition; Tx_valid follows two cycles after Rinc rises.
// Backpr. : no new frame starts while Busy is high; each frame waits for Busy to rise, then fall.
//
// Ports (read/transmit clock domain):
//   i_rclk         clock, rising edge
//   i_rrst         asynchronous reset, active low
//   i_enable       level; 1 allows new frames to start (sampled in IDLE only)
//   i_rempty       FIFO empty flag
//   i_rdata        FIFO head word, valid whenever i_rempty=0
//   o_rinc         one-cycle FIFO pop strobe
//   i_busy         UART TX busy
//   o_tx_data      word presented to the UART TX, held from pop to next pop
//   o_tx_valid     one-cycle load pulse to the UART TX
//   o_frames_sent  completed-frame counter, wraps
//   o_ctrl_busy    1 whenever the controller is not in IDLE
//
// Optional feature: define TX_GAP_EN to insert GAP_CYCLES idle cycles (Ctrl_busy=1)
// after every frame. Without it WAIT_LO returns straight to IDLE and the GAP
// state is unreachable.
`timescale 1ns/1ps

module fifo_tx_scheduler #(
  parameter int DATA_WIDTH   = 8,
  parameter int COUNT_WIDTH  = 8,
  parameter int BUSY_TIMEOUT = 15,
  parameter int GAP_CYCLES   = 4
) (
  input  logic                   i_rclk,
  input  logic                   i_rrst,
  input  logic                   i_enable,
  input  logic                   i_rempty,
  input  logic [DATA_WIDTH-1:0]  i_rdata,
  output logic                   o_rinc,
  input  logic                   i_busy,
  output logic [DATA_WIDTH-1:0]  o_tx_data,
  output logic                   o_tx_valid,
  output logic [COUNT_WIDTH-1:0] o_frames_sent,
  output logic                   o_ctrl_busy
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_POP     = 3'd1,
    S_SEND    = 3'd2,
    S_WAIT_HI = 3'd3,
    S_WAIT_LO = 3'd4,
    S_GAP     = 3'd5
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  logic                   r_rinc;
  logic                   r_tx_valid;
  logic [DATA_WIDTH-1:0]  r_tx_data;
  logic [COUNT_WIDTH-1:0] r_frames;
  logic                   r_ctrl_busy;
  logic [TW-1:0]          r_tout_cnt;
  logic [GW-1:0]          r_gap_cnt;

  logic                   w_rinc_nxt;
  logic                   w_tx_valid_nxt;
  logic [DATA_WIDTH-1:0]  w_tx_data_nxt;
  logic [COUNT_WIDTH-1:0] w_frames_nxt;
  logic                   w_ctrl_busy_nxt;
  logic [TW-1:0]          w_tout_nxt;
  logic [GW-1:0]          w_gap_nxt;

  logic                   w_start;
  logic                   w_tout_done;
  logic                   w_gap_done;
  logic                   w_frame_done;

  // Busy high in IDLE means the serializer is still shifting the previous
  // frame (or something else owns it), so hold off the pop.
  assign w_start      = i_enable && !i_rempty && !i_busy;
  // WAIT_HI is entered with the counter at 0, so BUSY_TIMEOUT-1 is the last
  // cycle of the window; Busy is checked first so a rise on that edge wins.
  assign w_tout_done  = (r_tout_cnt == TW'(BUSY_TIMEOUT - 1));
  assign w_gap_done   = (r_gap_cnt == GW'(GAP_CYCLES - 1));
  assign w_frame_done = (r_state == S_WAIT_LO) && !i_busy;

  // State register
  always_ff @(posedge i_rclk or negedge i_rrst) begin
    if (!i_rrst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:    if (w_start) w_state_nxt = S_POP;
      S_POP:     w_state_nxt = S_SEND;
      S_SEND:    w_state_nxt = S_WAIT_HI;
      S_WAIT_HI: begin
        if (i_busy) begin
          w_state_nxt = S_WAIT_LO;
        end else if (w_tout_done) begin
          // Re-issue the same word; Tx_data is untouched and no pop happens.
          w_state_nxt = S_SEND;
        end
      end
      S_WAIT_LO: begin
        if (!i_busy) begin
`ifdef TX_GAP_EN
          w_state_nxt = S_GAP;
`else
          w_state_nxt = S_IDLE;
`endif
        end
      end
      S_GAP:     if (w_gap_done) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs and counters.
  always_comb begin
    w_rinc_nxt      = (r_state == S_IDLE) && w_start;
    // Word is captured on the same edge the pop strobe rises, while the
    // fall-through head is still the word being popped.
    w_tx_data_nxt   = w_rinc_nxt ? i_rdata : r_tx_data;
    w_tx_valid_nxt  = (r_state == S_SEND);
    w_frames_nxt    = w_frame_done ? (r_frames + 1'b1) : r_frames;
    w_ctrl_busy_nxt = (w_state_nxt != S_IDLE);
    // Counter only runs inside WAIT_HI; every other state (SEND included) clears it.
    w_tout_nxt      = (r_state == S_WAIT_HI) ? (r_tout_cnt + 1'b1) : '0;
    w_gap_nxt       = (r_state == S_GAP) ? (r_gap_cnt + 1'b1) : '0;
  end

  // Output and counter registers
  always_ff @(posedge i_rclk or negedge i_rrst) begin
    if (!i_rrst) begin
      r_rinc      <= 1'b0;
      r_tx_valid  <= 1'b0;
      r_tx_data   <= '0;
      r_frames    <= '0;
      r_ctrl_busy <= 1'b0;
      r_tout_cnt  <= '0;
      r_gap_cnt   <= '0;
    end else begin
      r_rinc      <= w_rinc_nxt;
      r_tx_valid  <= w_tx_valid_nxt;
      r_tx_data   <= w_tx_data_nxt;
      r_frames    <= w_frames_nxt;
      r_ctrl_busy <= w_ctrl_busy_nxt;
      r_tout_cnt  <= w_tout_nxt;
      r_gap_cnt   <= w_gap_nxt;
    end
  end

  assign o_rinc        = r_rinc;
  assign o_tx_valid    = r_tx_valid;
  assign o_tx_data     = r_tx_data;
  assign o_frames_sent = r_frames;
  assign o_ctrl_busy   = r_ctrl_busy;

endmodule

// File: tb/tb_fifo_tx_scheduler.sv
// Testbench for fifo_tx_scheduler: FIFO model, UART busy model, table of
// drain scenarios plus hand-written reset, timeout, enable-drop, busy-block
// and inter-frame gap sequences.
`timescale 1ns/1ps

module tb_fifo_tx_scheduler;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rrst;
  logic       enable;
  logic       force_busy;
  logic       model_busy = 1'b0;
  logic       busy;
  logic       rempty;
  logic [7:0] rdata;
  logic       rinc;
  logic       tx_valid;
  logic       ctrl_busy;
  logic [7:0] tx_data;
  logic [7:0] frames;

  assign busy = model_busy | force_busy;

  fifo_tx_scheduler #(
    .DATA_WIDTH  (8),
    .COUNT_WIDTH (8),
    .BUSY_TIMEOUT(15),
    .GAP_CYCLES  (4)
  ) dut (
    .i_rclk       (clk),
    .i_rrst       (rrst),
    .i_enable     (enable),
    .i_rempty     (rempty),
    .i_rdata      (rdata),
    .o_rinc       (rinc),
    .i_busy       (busy),
    .o_tx_data    (tx_data),
    .o_tx_valid   (tx_valid),
    .o_frames_sent(frames),
    .o_ctrl_busy  (ctrl_busy)
  );

  // FIFO model (first-word fall-through); pops on the cycle Rinc is high.
  logic [7:0] mem [0:63];
  int wr_ptr = 0;
  int rd_ptr = 0;
  assign rempty = (wr_ptr == rd_ptr);
  assign rdata  = mem[rd_ptr[5:0]];

  // Monitor
  int cyc = 0;
  int rinc_cnt = 0;
  int txv_cnt = 0;
  int rinc_cyc = 0;
  int underflow = 0;
  int txv_cyc [0:63];
  logic [7:0] txv_dat [0:63];
  logic [7:0] pop_dat [0:63];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rinc) begin
      rinc_cnt <= rinc_cnt + 1;
      rinc_cyc <= cyc;
      pop_dat[rinc_cnt[5:0]] <= tx_data;
      rd_ptr <= rd_ptr + 1;
      if (rempty) underflow <= underflow + 1;
    end
    if (tx_valid) begin
      txv_cnt <= txv_cnt + 1;
      txv_cyc[txv_cnt[5:0]] <= cyc;
      txv_dat[txv_cnt[5:0]] <= tx_data;
    end
  end

  // UART busy model: b_dly cycles after Tx_valid Busy rises, stays high b_len cycles.
  int b_dly = 1;
  int b_len = 10;
  int b_pend = 0;
  int b_hi = 0;
  int busy_fall_cyc = 0;

  always @(negedge clk) begin
    if (b_hi > 0) begin
      b_hi <= b_hi - 1;
      if (b_hi == 1) begin
        model_busy    <= 1'b0;
        busy_fall_cyc <= cyc;
      end
    end else if (b_pend > 0) begin
      b_pend <= b_pend - 1;
      if (b_pend == 1) begin
        model_busy <= 1'b1;
        b_hi       <= b_len;
      end
    end else if (tx_valid && !busy) begin
      b_pend <= b_dly;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    mem[wr_ptr[5:0]] = d;
    wr_ptr++;
  endtask

  task automatic wait_quiet(input string nm);
    int q;
    int n;
    q = 0;
    n = 0;
    while (q < 4 && n < 3000) begin
      @(negedge clk); #1;
      n++;
      if (!ctrl_busy && !busy && b_pend == 0 && (rempty || !enable)) q++;
      else q = 0;
    end
    check({nm, "_settled"}, (q >= 4) ? 1 : 0, 1);
  endtask

  task automatic wait_txv(input int target, input string nm);
    int n;
    n = 0;
    while (txv_cnt < target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check({nm, "_txv_reached"}, (txv_cnt >= target) ? 1 : 0, 1);
  endtask

  task automatic wait_rinc(input int target, input string nm);
    int n;
    n = 0;
    while (rinc_cnt < target && n < 2000) begin
      @(negedge clk); #1;
      n++;
    end
    check({nm, "_rinc_reached"}, (rinc_cnt >= target) ? 1 : 0, 1);
  endtask

  typedef struct {
    int         nwords;
    logic [7:0] base;
    int         dly;
    int         len;
    logic       en;
    int         exp_rinc;
    int         exp_txv;
    int         exp_frm;
    logic [7:0] exp_data;
    int         exp_left;
  } vec_t;

  vec_t vt [5];

  initial begin
    int r0;
    int t0;
    int exp_frames;
    int n;
    int gap;

    vt[0] = '{1, 8'h11, 1, 10, 1'b1, 1, 1, 1, 8'h11, 0};  // single word
    vt[1] = '{8, 8'h0B, 1, 10, 1'b1, 8, 8, 8, 8'h12, 0};  // drain 8 words
    vt[2] = '{2, 8'h40, 1, 10, 1'b0, 0, 0, 0, 8'h12, 2};  // disabled: nothing moves
    vt[3] = '{1, 8'h50, 2, 3,  1'b1, 3, 3, 3, 8'h50, 0};  // re-enable drains backlog
    vt[4] = '{3, 8'h20, 3, 1,  1'b1, 3, 3, 3, 8'h22, 0};  // short busy pulses

    rrst       = 1'b0;
    enable     = 1'b0;
    force_busy = 1'b0;
    exp_frames = 0;

    #2;
    check("rst_tx_valid",  int'(tx_valid),  0);
    check("rst_rinc",      int'(rinc),      0);
    check("rst_tx_data",   int'(tx_data),   0);
    check("rst_frames",    int'(frames),    0);
    check("rst_ctrl_busy", int'(ctrl_busy), 0);
    repeat (3) @(negedge clk);
    #1 rrst = 1'b1;

    // Table-driven drain scenarios
    for (int i = 0; i < 5; i++) begin
      r0     = rinc_cnt;
      t0     = txv_cnt;
      b_dly  = vt[i].dly;
      b_len  = vt[i].len;
      enable = vt[i].en;
      for (int k = 0; k < vt[i].nwords; k++) push(vt[i].base + 8'(k));
      wait_quiet($sformatf("v%0d", i));
      exp_frames = (exp_frames + vt[i].exp_frm) % 256;
      check($sformatf("v%0d_rinc", i),      rinc_cnt - r0,     vt[i].exp_rinc);
      check($sformatf("v%0d_txv", i),       txv_cnt - t0,      vt[i].exp_txv);
      check($sformatf("v%0d_frames", i),    int'(frames),      exp_frames);
      check($sformatf("v%0d_tx_data", i),   int'(tx_data),     int'(vt[i].exp_data));
      check($sformatf("v%0d_left", i),      wr_ptr - rd_ptr,   vt[i].exp_left);
      check($sformatf("v%0d_ctrl_busy", i), int'(ctrl_busy),   0);
      for (int k = r0; k < rinc_cnt; k++)
        check($sformatf("v%0d_order%0d", i, k), int'(pop_dat[k[5:0]]), int'(mem[k[5:0]]));
    end

    // Reset while in WAIT_LO
    b_dly = 1;
    b_len = 10;
    r0 = rinc_cnt;
    push(8'h77);
    n = 0;
    while (!busy && n < 200) begin
      @(negedge clk); #1;
      n++;
    end
    check("rwl_busy_seen", int'(busy), 1);
    repeat (2) @(negedge clk);
    #1;
    check("rwl_pre_ctrl_busy", int'(ctrl_busy), 1);
    check("rwl_pre_tx_data",   int'(tx_data),   8'h77);
    rrst = 1'b0;
    #0.5;
    check("rwl_tx_valid",  int'(tx_valid),  0);
    check("rwl_rinc",      int'(rinc),      0);
    check("rwl_tx_data",   int'(tx_data),   0);
    check("rwl_frames",    int'(frames),    0);
    check("rwl_ctrl_busy", int'(ctrl_busy), 0);
    #0.5;
    rrst = 1'b1;
    exp_frames = 0;
    repeat (20) @(negedge clk);
    #1;
    check("rwl_no_repop",    rinc_cnt - r0,   1);
    check("rwl_idle_after",  int'(ctrl_busy), 0);
    wait_quiet("rwl");
    check("rwl_frames_after", int'(frames), 0);

    // Busy timeout: no response for 20 cycles, re-issue after 16
    b_dly = 20;
    b_len = 3;
    r0 = rinc_cnt;
    t0 = txv_cnt;
    push(8'h5A);
    wait_txv(t0 + 2, "to");
    check("to_rinc_to_valid", txv_cyc[t0[5:0]] - rinc_cyc, 2);
    check("to_reissue_gap",   txv_cyc[(t0 + 1) % 64] - txv_cyc[t0[5:0]], 16);
    check("to_data_first",    int'(txv_dat[t0[5:0]]), 8'h5A);
    check("to_data_second",   int'(txv_dat[(t0 + 1) % 64]), 8'h5A);
    wait_quiet("to");
    exp_frames++;
    check("to_rinc",   rinc_cnt - r0, 1);
    check("to_txv",    txv_cnt - t0,  2);
    check("to_frames", int'(frames),  exp_frames);

    // Enable dropped during WAIT_HI of word 3 of 5
    b_dly = 4;
    b_len = 5;
    r0 = rinc_cnt;
    t0 = txv_cnt;
    for (int k = 0; k < 5; k++) push(8'h31 + 8'(k));
    wait_txv(t0 + 3, "en");
    enable = 1'b0;
    wait_quiet("en_drop");
    check("en_drop_rinc",    rinc_cnt - r0,   3);
    check("en_drop_frames",  int'(frames),    exp_frames + 3);
    check("en_drop_left",    wr_ptr - rd_ptr, 2);
    check("en_drop_tx_data", int'(tx_data),   8'h33);
    enable = 1'b1;
    wait_quiet("en_resume");
    exp_frames += 5;
    check("en_resume_rinc",    rinc_cnt - r0,   5);
    check("en_resume_frames",  int'(frames),    exp_frames);
    check("en_resume_tx_data", int'(tx_data),   8'h35);
    check("en_resume_left",    wr_ptr - rd_ptr, 0);

    // Busy already high in IDLE blocks the start
    force_busy = 1'b1;
    b_dly = 1;
    b_len = 2;
    r0 = rinc_cnt;
    push(8'h66);
    repeat (10) @(negedge clk);
    #1;
    check("bb_no_pop",    rinc_cnt - r0,   0);
    check("bb_ctrl_busy", int'(ctrl_busy), 0);
    force_busy = 1'b0;
    wait_quiet("bb");
    exp_frames++;
    check("bb_rinc",    rinc_cnt - r0,  1);
    check("bb_tx_data", int'(tx_data), 8'h66);
    check("bb_frames",  int'(frames),  exp_frames);

    // Busy falling to next Rinc
    b_dly = 1;
    b_len = 4;
    r0 = rinc_cnt;
    push(8'h71);
    push(8'h72);
    wait_rinc(r0 + 2, "gap");
    gap = rinc_cyc - busy_fall_cyc;
`ifdef TX_GAP_EN
    check("gap_fall_to_rinc", gap, 6);
`else
    check("gap_fall_to_rinc", gap, 2);
`endif
    wait_quiet("gap");
    exp_frames += 2;
    check("gap_frames",  int'(frames),  exp_frames);
    check("gap_tx_data", int'(tx_data), 8'h72);

    check("no_underflow_pop", underflow, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
